// File: rtl/detector_arbiter_pkg.sv
// Shared types and constants for the detector arbiter.
// Optional round-robin grant enabled by DETARB_RR_EN.
package detector_arbiter_pkg;

  localparam int FRAME_W = 8;
  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 3;
  localparam int IDX_W   = 2;

  localparam logic [2:0] MATCH = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DRAIN,
    ST_DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    S0,
    S1,
    S10,
    S101
  } det_state_t;

  // First requesting index found scanning upward from start.
  function automatic logic [IDX_W-1:0] arb_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [IDX_W-1:0]   start
  );
    logic [IDX_W-1:0] idx;
    arb_pick = start;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = start + IDX_W'(k);
      if (req[idx]) arb_pick = idx;
    end
  endfunction

endpackage

// File: rtl/detector_arbiter_seq_det.sv
// Moore "101" detector, overlapping matches.
// out is high only while in S101.
module seq_det
  import detector_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inp,
  output logic out
);

  det_state_t r_state;

  // Advance one pattern step per clock; clr restarts the search.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S0;
    end else if (clr) begin
      r_state <= S0;
    end else begin
      unique case (r_state)
        S0:   r_state <= (inp == MATCH[2]) ? S1 : S0;
        S1:   r_state <= (inp == MATCH[1]) ? S10 : S1;
        S10:  r_state <= (inp == MATCH[0]) ? S101 : S0;
        S101: r_state <= (inp == MATCH[1]) ? S10 : S1;
        default: r_state <= S0;
      endcase
    end
  end

  assign out = (r_state == S101);

endmodule

// File: rtl/detector_arbiter.sv
// Arbitrates 4 requesters; counts "101" in the granted frame.
// DETARB_RR_EN selects round-robin, else fixed priority.
module detector_arbiter
  import detector_arbiter_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*FRAME_W-1:0] frame_in,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           count
);

  arb_state_t         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_count;
  logic [2:0]         r_bitcnt;
  logic [FRAME_W-1:0] r_shift;
  logic [IDX_W-1:0]   r_idx;

  logic [IDX_W-1:0]   w_start;
  logic [IDX_W-1:0]   w_sel;
  logic               w_det_clr;
  logic               w_det_out;

`ifdef DETARB_RR_EN
  logic [IDX_W-1:0] r_ptr;

  assign w_start = r_ptr;

  // Move priority just past the requester finishing service.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (r_state == ST_DONE) begin
      r_ptr <= r_idx + IDX_W'(1);
    end
  end
`else
  assign w_start = '0;
`endif

  assign w_sel     = arb_pick(req, w_start);
  assign w_det_clr = (r_state == ST_LOAD);

  seq_det u_det (
    .clk (clk),
    .rst (rst),
    .clr (w_det_clr),
    .inp (r_shift[FRAME_W-1]),
    .out (w_det_out)
  );

  // Service FSM with registered grant, busy, done and count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_count  <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_idx    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_state <= ST_LOAD;
            r_idx   <= w_sel;
            r_gnt   <= NUM_REQ'(1) << w_sel;
            r_busy  <= 1'b1;
            r_count <= '0;
          end
        end
        ST_LOAD: begin
          r_shift  <= frame_in[{r_idx, 3'b000} +: FRAME_W];
          r_bitcnt <= '0;
          r_state  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
          if (w_det_out && r_bitcnt != 3'd0) begin
            r_count <= r_count + CNT_W'(1);
          end
          if (r_bitcnt == 3'd7) begin
            r_state <= ST_DRAIN;
          end else begin
            r_bitcnt <= r_bitcnt + 3'd1;
          end
        end
        ST_DRAIN: begin
          if (w_det_out) begin
            r_count <= r_count + CNT_W'(1);
          end
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign busy  = r_busy;
  assign done  = r_done;
  assign count = r_count;

endmodule

// File: tb/tb_detector_arbiter.sv
// Scoreboard bench for detector_arbiter.
// Reference model counts "101" windows directly.
module tb_detector_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] frame_in = '0;
  logic [3:0]  gnt;
  logic        busy;
  logic        done;
  logic [2:0]  count;

  detector_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .frame_in (frame_in),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic [2:0] c;
  } exp_t;

  exp_t       q[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         m_ptr = 0;
  logic [2:0] last_cnt = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  // Number of (overlapping) 101 windows, MSB first.
  function automatic int ref_count(input logic [7:0] f);
    int n;
    n = 0;
    for (int i = 7; i >= 2; i--)
      if (f[i] && !f[i-1] && f[i-2]) n++;
    return n;
  endfunction

  function automatic int ref_pick(input logic [3:0] r,
                                  input int p);
`ifdef DETARB_RR_EN
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
`else
    for (int k = 0; k < 4; k++)
      if (r[k]) return k;
    if (p < 0) return 0;
`endif
    return 0;
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", {31'b0, busy}, 32'd0);
  endtask

  // pmode: 0 hold, 1 random change, 2 frame=FF and req dropped
  task automatic run_txn(input logic [3:0] r,
                         input logic [31:0] fr,
                         input int pmode);
    int   sel;
    int   k;
    exp_t e;
    wait_idle();
    req = r;
    frame_in = fr;
    sel = ref_pick(r, m_ptr);
    e.g = 4'(1 << sel);
    e.c = 3'(ref_count(fr[8*sel +: 8]));
    q.push_back(e);
`ifdef DETARB_RR_EN
    m_ptr = (sel + 1) % 4;
`endif
    last_cnt = e.c;
    k = 0;
    @(negedge clk);
    while (gnt == 4'b0 && k < 4) begin
      @(negedge clk);
      k++;
    end
    chk("gnt_start", {28'b0, gnt}, {28'b0, e.g});
    @(negedge clk);
    if (pmode == 1) begin
      frame_in = $urandom;
      req = 4'($urandom);
    end else if (pmode == 2) begin
      frame_in = 32'hFFFF_FFFF;
      req = 4'b0;
    end
  endtask

  task automatic idle_gap(input int n);
    wait_idle();
    req = '0;
    repeat (n) begin
      @(negedge clk);
      chk("idle_gnt", {28'b0, gnt}, 32'd0);
      chk("idle_done", {31'b0, done}, 32'd0);
      chk("idle_count", {29'b0, count}, {29'b0, last_cnt});
    end
  endtask

  // Monitor: pops an expectation on every done pulse.
  int gcyc = 0;
  bit after_done = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        gcyc = 0;
        after_done = 0;
      end else begin
        if (gnt != 4'b0) gcyc++;
        else gcyc = 0;
        if (done) begin
          if (q.size() == 0) begin
            chk("done_unexpected", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("done_gnt", {28'b0, gnt}, {28'b0, e.g});
            chk("done_count", {29'b0, count}, {29'b0, e.c});
            chk("gnt_cycles", gcyc, 32'd11);
            chk("done_busy", {31'b0, busy}, 32'd1);
          end
          after_done = 1;
        end else if (after_done) begin
          chk("gnt_release", {28'b0, gnt}, 32'd0);
          chk("done_width", {31'b0, done}, 32'd0);
          after_done = 0;
        end
      end
    end
  end

  initial begin
    exp_t dropped;
    logic [3:0] r;
    repeat (3) @(negedge clk);
    chk("rst_gnt", {28'b0, gnt}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    repeat (4) run_txn(4'hF, $urandom, 0);
    idle_gap(2);

    run_txn(4'b0001, 32'h0000_00AA, 0);
    run_txn(4'b0010, 32'h0000_A500, 0);
    run_txn(4'b0010, 32'h0000_0000, 0);
    run_txn(4'b0001, 32'h0000_00AA, 2);
    idle_gap(2);

    run_txn(4'b0001, 32'h0000_00AA, 0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_gnt", {28'b0, gnt}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_count", {29'b0, count}, 32'd0);
    dropped = q.pop_back();
    m_ptr = 0;
    last_cnt = '0;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_txn(4'b0100, $urandom, 0);
    idle_gap(1);

    for (int i = 0; i < 24; i++) begin
      r = 4'($urandom_range(1, 15));
      run_txn(r, $urandom, int'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_gap(1);
    end

    idle_gap(3);
    chk("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/detector_arbiter.md
DETECTOR_ARBITER -- requirements
Module: detector_arbiter

Interface
REQ-001 clk  input  1  rising-edge system clock.
REQ-002 rst  input  1  asynchronous, active-low reset; all state clears while rst=0.
REQ-003 req  input  4  per-requester service request; req[i] is held by requester i until its done pulse.
REQ-004 frame_in  input  32  requester frames; frame_in[8*i+7:8*i] belongs to requester i.
REQ-005 gnt  output  4  one-hot grant to the requester being served; 0 when idle.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 done  output  1  one-cycle pulse marking count valid for the granted requester.
REQ-008 count  output  3  number of "101" detections in the served frame; holds until the next LOAD.

Function
REQ-009 The block SHALL serialise one granted 8-bit frame, MSB first, into a single shared Moore "101" sequence detector and count its detections.
REQ-010 States SHALL be IDLE, LOAD, SHIFT, DRAIN and DONE.
REQ-011 IDLE -> LOAD on any req bit = 1; otherwise the block stays in IDLE.
REQ-012 LOAD: one cycle; captures the selected frame into the shift register; clears the detector to S0; clears count; asserts gnt.
REQ-013 SHIFT: exactly 8 cycles, one bit per cycle into the detector; bit counter 0..7; at counter = 7 -> DRAIN.
REQ-014 DRAIN: one cycle, so the detector output for bit 8 is observed.
REQ-015 DONE: one cycle with done = 1; then -> IDLE. Back-to-back service therefore has at least one IDLE cycle.
REQ-016 gnt SHALL be asserted from LOAD through DONE inclusive: 11 cycles. done SHALL rise 10 cycles after gnt rises.
REQ-017 The detector is Moore with states S0, S1, S10, S101 and out = 1 only in S101; overlapping matches are counted (S101 on 0 -> S10).
REQ-018 count SHALL increment on each cycle with detector out = 1 during SHIFT cycles 1..7 and DRAIN. Maximum value is 3; 3 bits never overflow.
REQ-019 req and frame_in SHALL be sampled only in IDLE and LOAD respectively. Changes during SHIFT, DRAIN or DONE are ignored, including a req drop.
REQ-020 Grant selection SHALL use rotating priority or fixed priority as set by REQ-024.
REQ-021 With no req in IDLE: gnt = 0, done = 0, count held.

Reset
REQ-022 While rst = 0, asynchronously: state = IDLE, gnt = 0, busy = 0, done = 0, count = 0, bit counter = 0, detector = S0, priority pointer = 0.
REQ-023 Reset asserted in any state SHALL abort the transaction with no done pulse. After release, the block resumes from IDLE on the next rising edge.

Configuration
REQ-024 Macro DETARB_RR_EN:
- Defined: round-robin. Search starts at pointer; pointer = granted index + 1 (mod 4) on DONE.
- Undefined: fixed priority, req[0] highest; pointer logic removed.

Structure
REQ-025 A shared package SHALL hold the state enum, the detector state enum, the constants FRAME_W = 8, NUM_REQ = 4, CNT_W = 3, and the match pattern 3'b101.
REQ-026 The detector SHALL be a separate sub-module seq_det with ports clk, rst, clr, inp, out. detector_arbiter instantiates it once.

Verification
REQ-027 req = 0001, frame0 = 8'b10101010 -> gnt = 0001 for 11 cycles, done pulse on the 11th cycle, count = 3.
REQ-028 req = 0010, frame1 = 8'b10100101 -> count = 2; frame1 = 8'h00 -> count = 0.
REQ-029 req = 1111 held through four transactions:
- with DETARB_RR_EN: grants in order 0001, 0010, 0100, 1000;
- without DETARB_RR_EN: 0001 every time.
REQ-030 rst = 0 mid-SHIFT, for example at bit 4 -> gnt, busy and count are 0 immediately with no done pulse; after release, req = 0100 -> fresh 11-cycle transaction to requester 2.
REQ-031 After LOAD, change frame0 from 8'b10101010 to 8'hFF and drop req[0] -> count = 3 and done still pulses.
